// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the life_array_p cellular automaton.
//   state_e    : run-control FSM states (IDLE / RUN / DONE)
//   BIRTH_B3   : Conway birth mask (born with exactly 3 neighbours)
//   SURV_S23   : Conway survival mask (survive with 2 or 3 neighbours)
//   popcount8  : number of set bits in an 8-bit neighbour vector (0..8)
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [8:0] BIRTH_B3 = 9'h008;
  localparam logic [8:0] SURV_S23 = 9'h00C;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'd0, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/life_cell.sv
// life_cell: one grid cell. Holds the cell state, counts live neighbours,
// applies the birth/survival rule and flags whether the rule would change it.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   clr             : synchronous clear of the cell
//   wr_en, wr_data  : direct write of this cell (already address-decoded)
//   step_en         : advance one generation
//   nb[7:0]         : neighbour states (border masking done by the parent)
//   birth_mask      : bit k set -> dead cell with k neighbours is born
//   surv_mask       : bit k set -> live cell with k neighbours survives
//   alive           : current cell state
//   changed         : next generation value differs from current state
module life_cell
  import life_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_en,
  input  logic       wr_data,
  input  logic       step_en,
  input  logic [7:0] nb,
  input  logic [8:0] birth_mask,
  input  logic [8:0] surv_mask,
  output logic       alive,
  output logic       changed
);

  logic       alive_q;
  logic       alive_d;
  logic [3:0] cnt_s;
  logic       next_s;

  // Rule evaluation and next-state selection (clear > write > step).
  always_comb begin
    cnt_s   = popcount8(nb);
    next_s  = alive_q ? surv_mask[cnt_s] : birth_mask[cnt_s];
    alive_d = alive_q;
    if (clr) begin
      alive_d = 1'b0;
    end else if (wr_en) begin
      alive_d = wr_data;
    end else if (step_en) begin
      alive_d = next_s;
    end else begin
      alive_d = alive_q;
    end
  end

  // Cell state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= alive_d;
    end
  end

  assign alive   = alive_q;
  assign changed = next_s ^ alive_q;

endmodule

// File: rtl/life_array_p.sv
// life_array_p: NX x NY parallel Game-of-Life style array. Every cell steps
// once per clock while the FSM is in RUN.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   clr                        : sync clear of grid, counters, stable and FSM
//   wr_en/wr_x/wr_y/wr_data    : single-cell write, accepted only in IDLE
//   rd_x/rd_y -> rd_data       : registered cell read (one cycle latency)
//   vga_x/vga_y -> vga_data    : combinational cell read
//   wrap                       : 0 dead border, 1 toroidal (latched at start)
//   birth_mask/surv_mask       : rule masks (latched at start)
//   start/n_gen                : run request for n_gen generations
//   busy/done/stable           : run status
//   gen_count                  : generations computed since clear (saturating)
module life_array_p
  import life_pkg::*;
#(
  parameter  int NX    = 16,
  parameter  int NY    = 16,
  parameter  int GEN_W = 16,
  localparam int XW    = $clog2(NX),
  localparam int YW    = $clog2(NY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic             wr_data,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  output logic             rd_data,
  input  logic [XW-1:0]    vga_x,
  input  logic [YW-1:0]    vga_y,
  output logic             vga_data,
  input  logic             wrap,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       surv_mask,
  input  logic             start,
  input  logic [GEN_W-1:0] n_gen,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  // Address space padded to a power of two so any {y,x} indexes safely;
  // padding entries read 0 and are flagged invalid for writes.
  localparam int PX = 1 << XW;
  localparam int PY = 1 << YW;

  state_e           state_q, state_d;
  logic [GEN_W-1:0] remaining_q, remaining_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             stable_q, stable_d;
  logic             wrap_q, wrap_d;
  logic [8:0]       birth_q, birth_d;
  logic [8:0]       surv_q, surv_d;
  logic             rd_data_q, rd_data_d;

  logic [NX*NY-1:0] cell_s;
  logic [NX*NY-1:0] changed_s;
  logic [PX*PY-1:0] pad_s;
  logic [PX*PY-1:0] valid_pad_s;
  logic             step_en_s;
  logic             wr_go_s;
  logic             wr_ok_s;
  logic             any_changed_s;

  assign wr_go_s       = wr_en & ~clr & (state_q == IDLE);
  assign wr_ok_s       = valid_pad_s[{wr_y, wr_x}];
  assign any_changed_s = |changed_s;

  genvar gx, gy;

  // Padded address map.
  generate
    for (gy = 0; gy < PY; gy++) begin : g_pad_y
      for (gx = 0; gx < PX; gx++) begin : g_pad_x
        if ((gx < NX) && (gy < NY)) begin : g_in
          assign pad_s[gy*PX+gx]       = cell_s[gy*NX+gx];
          assign valid_pad_s[gy*PX+gx] = 1'b1;
        end else begin : g_out
          assign pad_s[gy*PX+gx]       = 1'b0;
          assign valid_pad_s[gy*PX+gx] = 1'b0;
        end
      end
    end
  endgenerate

  // Cell array with neighbour wiring. Wrapped indices are always used; on a
  // border the neighbour is masked unless wrap is enabled.
  generate
    for (gy = 0; gy < NY; gy++) begin : g_row
      for (gx = 0; gx < NX; gx++) begin : g_col
        localparam int   XL = (gx == 0)      ? NX - 1 : gx - 1;
        localparam int   XR = (gx == NX - 1) ? 0      : gx + 1;
        localparam int   YU = (gy == 0)      ? NY - 1 : gy - 1;
        localparam int   YD = (gy == NY - 1) ? 0      : gy + 1;
        localparam logic EL = (gx == 0);
        localparam logic ER = (gx == NX - 1);
        localparam logic EU = (gy == 0);
        localparam logic ED = (gy == NY - 1);

        logic [7:0] nb_s;
        logic       wr_sel_s;

        assign nb_s[0] = cell_s[YU*NX+XL] & (wrap_q | ~(EU | EL));
        assign nb_s[1] = cell_s[YU*NX+gx] & (wrap_q | ~EU);
        assign nb_s[2] = cell_s[YU*NX+XR] & (wrap_q | ~(EU | ER));
        assign nb_s[3] = cell_s[gy*NX+XL] & (wrap_q | ~EL);
        assign nb_s[4] = cell_s[gy*NX+XR] & (wrap_q | ~ER);
        assign nb_s[5] = cell_s[YD*NX+XL] & (wrap_q | ~(ED | EL));
        assign nb_s[6] = cell_s[YD*NX+gx] & (wrap_q | ~ED);
        assign nb_s[7] = cell_s[YD*NX+XR] & (wrap_q | ~(ED | ER));

        assign wr_sel_s = wr_go_s & (wr_x == XW'(gx)) & (wr_y == YW'(gy));

        life_cell u_cell (
          .clk        (clk),
          .rst_n      (rst_n),
          .clr        (clr),
          .wr_en      (wr_sel_s),
          .wr_data    (wr_data),
          .step_en    (step_en_s),
          .nb         (nb_s),
          .birth_mask (birth_q),
          .surv_mask  (surv_q),
          .alive      (cell_s[gy*NX+gx]),
          .changed    (changed_s[gy*NX+gx])
        );
      end
    end
  endgenerate

  // Run-control FSM, counters, latched run configuration and read port.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    wrap_d      = wrap_q;
    birth_d     = birth_q;
    surv_d      = surv_q;
    step_en_s   = 1'b0;
    rd_data_d   = pad_s[{rd_y, rd_x}];
    if (clr) begin
      state_d     = IDLE;
      remaining_d = '0;
      gen_count_d = '0;
      stable_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_go_s && wr_ok_s) begin
            stable_d = 1'b0;
          end else begin
            stable_d = stable_q;
          end
          if (start) begin
            wrap_d      = wrap;
            birth_d     = birth_mask;
            surv_d      = surv_mask;
            stable_d    = 1'b0;
            remaining_d = n_gen;
            state_d     = (n_gen == '0) ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          step_en_s   = 1'b1;
          remaining_d = remaining_q - GEN_W'(1);
          gen_count_d = (gen_count_q == '1) ? gen_count_q : gen_count_q + GEN_W'(1);
          // A generation that changes nothing means every later one is
          // identical, so stop early and report the grid as stable.
          if (!any_changed_s) begin
            stable_d = 1'b1;
            state_d  = DONE;
          end else if (remaining_q == GEN_W'(1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      wrap_q      <= 1'b0;
      birth_q     <= BIRTH_B3;
      surv_q      <= SURV_S23;
      rd_data_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
      wrap_q      <= wrap_d;
      birth_q     <= birth_d;
      surv_q      <= surv_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign stable    = stable_q;
  assign gen_count = gen_count_q;
  assign rd_data   = rd_data_q;
  assign vga_data  = pad_s[{vga_y, vga_x}];

endmodule

// File: doc/life_array_p.md
LIFE_ARRAY_P -- requirements
Module: life_array_p

Interface
REQ-001 SHALL have parameter NX, default 16, number of grid columns (>=3).
REQ-002 SHALL have parameter NY, default 16, number of grid rows (>=3).
REQ-003 SHALL have parameter GEN_W, default 16, width of the generation count and step request; XW=$clog2(NX) and YW=$clog2(NY) SHALL be derived.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port clr  in  1  synchronous clear of grid, counters and FSM.
REQ-008 SHALL have ports wr_en / wr_x / wr_y / wr_data  in  1/XW/YW/1  single-cell write.
REQ-009 SHALL have ports rd_x / rd_y  in  XW/YW, and port rd_data  out  1, registered cell read.
REQ-010 SHALL have ports vga_x / vga_y  in  XW/YW, and port vga_data  out  1, combinational display read.
REQ-011 SHALL have port wrap  in  1  edge mode: 0 = dead border, 1 = toroidal.
REQ-012 SHALL have ports birth_mask / surv_mask  in  9/9  rule bit k = neighbour count k.
REQ-013 SHALL have ports start  in  1 and n_gen  in  GEN_W  run request.
REQ-014 SHALL have ports busy / done / stable  out  1/1/1  run status.
REQ-015 SHALL have port gen_count  out  GEN_W  generations computed since clear.

Function
REQ-016 SHALL hold NX*NY 1-bit cells; each cell SHALL have 8 neighbours; with wrap=0, out-of-grid neighbours SHALL read 0; with wrap=1, indices SHALL wrap modulo NX/NY.
REQ-017 SHALL compute next state in one step: dead cell -> 1 iff birth_mask[count]; live cell -> 1 iff surv_mask[count].
REQ-018 SHALL update all cells simultaneously, one generation per clk cycle in RUN.
REQ-019 SHALL use FSM states IDLE, RUN and DONE.
REQ-020 IDLE SHALL accept start: latch n_gen into remaining counter, latch wrap/masks, clear stable, go to RUN; if n_gen=0 it SHALL go to DONE directly without a step.
REQ-021 RUN SHALL compute one generation per cycle, decrement remaining and increment gen_count, saturating at 2^GEN_W-1.
REQ-022 RUN SHALL go to DONE when remaining reaches 0, or early when a generation changes no cell; in the early case stable SHALL be set.
REQ-023 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE; start SHALL be ignored while busy=1.
REQ-025 wr_en SHALL write only in IDLE; writes while busy=1 SHALL be dropped; any accepted write SHALL clear stable.
REQ-026 rd_data SHALL be the cell value at (rd_x,rd_y) one cycle after sampling.
REQ-027 vga_data SHALL reflect (vga_x,vga_y) combinationally in all states.
REQ-028 Out-of-range addresses SHALL make writes no-ops and reads return 0.
REQ-029 clr SHALL zero all cells, gen_count and stable, and force IDLE without a done pulse, even mid-RUN.
REQ-030 clr SHALL take priority over a same-cycle wr_en or start.
REQ-031 After a start-to-done run, the run SHALL have taken n_gen+1 cycles when not stopped early.

Reset
REQ-032 rst_n=0 SHALL asynchronously force all cells to 0, the FSM to IDLE, and remaining/gen_count to 0.
REQ-033 rst_n=0 SHALL force busy, done, stable and rd_data to 0.
REQ-034 Latched wrap SHALL reset to 0 and latched masks SHALL reset to B3/S23.

Structure
REQ-035 Package life_pkg SHALL hold the FSM state enum and the default constants BIRTH_B3=9'h008 and SURV_S23=9'h00C.
REQ-036 One sub-module life_cell SHALL be instantiated NX*NY times via generate; it SHALL contain the state flop, neighbour popcount, rule evaluation and a changed flag.
REQ-037 The top level SHALL hold the FSM, the counters, the edge/wrap neighbour wiring, the address decode and the OR-reduction of changed flags.

Verification
REQ-038 Blinker test: wrap=0, Conway rules, write (5,4),(5,5),(5,6), n_gen=1 -> (4,5),(5,5),(6,5) live, done after 2 cycles, gen_count=1.
REQ-039 Block test: 2x2 block at (2,2), n_gen=100 -> stable=1, gen_count=1, grid unchanged.
REQ-040 Edge test: blinker at (0,4..6) -> wrap=1 gives (NX-1,5),(0,5),(1,5) after one step; wrap=0 gives only (0,5),(1,5).
REQ-041 Glider test: glider, wrap=1, n_gen=4*NX -> original pattern restored, gen_count=4*NX.
REQ-042 Zero/ignore test: n_gen=0 -> done on next cycle with gen_count unchanged; wr_en and start during RUN -> no effect.
REQ-043 Clear/reset test: clr mid-RUN -> no done, busy=0 next cycle, all cells 0; rst_n low mid-RUN -> all outputs 0 immediately.
